// File: rtl/nn_seq_ctrl.sv
// nn_seq_ctrl: sequencing controller for a small neural-network datapath.
//
// It streams a weight memory into the network shift chain, then runs
// inferences. Each inference has two phases. First it asks every input
// lane for data and waits for each lane to acknowledge. Then it collects
// every output lane once. A watchdog aborts an inference that takes too
// long.
//
// Ports:
//   clk_i, reset_i    clock, synchronous active-high reset
//   load_start_i      request a weight load (accepted in IDLE only)
//   infer_start_i     request one inference (accepted in IDLE only)
//   wmem_rd_o         weight memory read strobe
//   wmem_addr_o       weight memory address
//   wmem_data_i       weight memory read data, one cycle after the strobe
//   shift_o           network shift enable
//   weights_o         word shifted into the network
//   req_o / ack_i     input-lane request/acknowledge
//   nn_req_i          output-lane request from the network
//   nn_ack_o          output-lane acknowledge to the network
//   busy_o            controller not idle
//   loaded_o          weights loaded (sticky)
//   done_o            inference-complete pulse
//   error_o           sticky error: infer before load, or watchdog expiry
module nn_seq_ctrl #(
  parameter int unsigned NumWeights     = 24,
  parameter int unsigned NumInputLayer  = 2,
  parameter int unsigned NumOutputLayer = 2,
  parameter int unsigned TimeoutCycles  = 1024
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          load_start_i,
  input  logic                          infer_start_i,
  output logic                          wmem_rd_o,
  output logic [$clog2(NumWeights)-1:0] wmem_addr_o,
  input  logic [31:0]                   wmem_data_i,
  output logic                          shift_o,
  output logic [31:0]                   weights_o,
  output logic [NumInputLayer-1:0]      req_o,
  input  logic [NumInputLayer-1:0]      ack_i,
  input  logic [NumOutputLayer-1:0]     nn_req_i,
  output logic [NumOutputLayer-1:0]     nn_ack_o,
  output logic                          busy_o,
  output logic                          loaded_o,
  output logic                          done_o,
  output logic                          error_o
);

  localparam int unsigned AW  = $clog2(NumWeights);
  localparam int unsigned WDW = $clog2(TimeoutCycles + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOAD_FLUSH,
    ISSUE,
    COLLECT,
    DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic                      shift_q;
  logic [31:0]               weights_q;
  logic [NumInputLayer-1:0]  req_q, req_d;
  logic [NumOutputLayer-1:0] coll_q, coll_d;
  logic [WDW-1:0]            wd_q, wd_d;
  logic                      loaded_q, loaded_d;
  logic                      error_q, error_d;
  logic [NumOutputLayer-1:0] nn_ack;
  logic                      timeout;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    req_d    = req_q;
    coll_d   = coll_q;
    wd_d     = wd_q;
    loaded_d = loaded_q;
    error_d  = error_q;
    nn_ack   = '0;
    // The watchdog fires on the TimeoutCycles-th cycle spent in ISSUE/COLLECT.
    timeout  = ((state_q == ISSUE) || (state_q == COLLECT)) &&
               (wd_q == WDW'(TimeoutCycles - 1));

    unique case (state_q)
      IDLE: begin
        addr_d = '0;
        if (load_start_i) begin
          state_d = LOAD;
          error_d = 1'b0;
        end else if (infer_start_i) begin
          if (loaded_q) begin
            state_d = ISSUE;
            req_d   = '1;
            coll_d  = '0;
            wd_d    = '0;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      LOAD: begin
        if (addr_q == AW'(NumWeights - 1)) begin
          state_d = LOAD_FLUSH;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end

      LOAD_FLUSH: begin
        loaded_d = 1'b1;
        state_d  = IDLE;
      end

      ISSUE: begin
        if (timeout) begin
          error_d = 1'b1;
          req_d   = '0;
          state_d = IDLE;
        end else begin
          wd_d  = wd_q + 1'b1;
          // Acks on lanes that are no longer requesting fall out of the mask.
          req_d = req_q & ~ack_i;
          if (req_d == '0) begin
            state_d = COLLECT;
          end
        end
      end

      COLLECT: begin
        if (timeout) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d   = wd_q + 1'b1;
          nn_ack = nn_req_i & ~coll_q;
          coll_d = coll_q | nn_ack;
          if (&coll_d) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      shift_q   <= 1'b0;
      weights_q <= '0;
      req_q     <= '0;
      coll_q    <= '0;
      wd_q      <= '0;
      loaded_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      shift_q  <= (state_q == LOAD);
      req_q    <= req_d;
      coll_q   <= coll_d;
      wd_q     <= wd_d;
      loaded_q <= loaded_d;
      error_q  <= error_d;
      if (shift_q) begin
        weights_q <= wmem_data_i;
      end
    end
  end

  assign wmem_rd_o   = (state_q == LOAD);
  assign wmem_addr_o = addr_q;
  assign shift_o     = shift_q;
  // Read data arrives in the shift cycle itself; the register only holds
  // the last shifted word between shifts.
  assign weights_o   = shift_q ? wmem_data_i : weights_q;
  assign req_o       = req_q;
  assign nn_ack_o    = nn_ack;
  assign busy_o      = (state_q != IDLE);
  assign loaded_o    = loaded_q;
  assign done_o      = (state_q == DONE);
  assign error_o     = error_q;

endmodule

// File: tb/tb_nn_seq_ctrl.sv
// Self-checking bench for nn_seq_ctrl (NumWeights=4, TimeoutCycles=8).
module tb_nn_seq_ctrl;

  localparam int NW = 4;
  localparam int NI = 2;
  localparam int NO = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic          infer = 1'b0;
  logic          wmem_rd;
  logic [1:0]    wmem_addr;
  logic [31:0]   wmem_data = '0;
  logic          shift;
  logic [31:0]   weights;
  logic [NI-1:0] req;
  logic [NI-1:0] ack = '0;
  logic [NO-1:0] nn_req = '0;
  logic [NO-1:0] nn_ack;
  logic          busy, loaded, done, error;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  logic [31:0] mem [NW];
  logic [31:0] shifted [$];
  int done_cnt = 0;

  nn_seq_ctrl #(
    .NumWeights    (NW),
    .NumInputLayer (NI),
    .NumOutputLayer(NO),
    .TimeoutCycles (TO)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .load_start_i (load),
    .infer_start_i(infer),
    .wmem_rd_o    (wmem_rd),
    .wmem_addr_o  (wmem_addr),
    .wmem_data_i  (wmem_data),
    .shift_o      (shift),
    .weights_o    (weights),
    .req_o        (req),
    .ack_i        (ack),
    .nn_req_i     (nn_req),
    .nn_ack_o     (nn_ack),
    .busy_o       (busy),
    .loaded_o     (loaded),
    .done_o       (done),
    .error_o      (error)
  );

  always #5 clk = ~clk;

  // Synchronous weight memory: data one cycle after the read strobe.
  always @(posedge clk) if (wmem_rd) wmem_data <= mem[wmem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases of the controller's job, each with its own progress counter.
  typedef enum {PH_IDLE, PH_READ, PH_TAIL, PH_ASK, PH_GATHER, PH_FIN} phase_e;
  phase_e        ph = PH_IDLE;
  int            step = 0;      // next weight index being read
  int            ticks = 0;     // cycles already spent in the inference window
  bit            m_shift = 0;   // a read happened last cycle
  int            m_sidx = 0;    // which weight that read fetched
  logic [31:0]   m_lastw = '0;
  bit            m_loaded = 0, m_err = 0;
  bit [NI-1:0]   m_pend = '0;
  bit [NO-1:0]   m_coll = '0;

  always @(posedge clk) begin
    if (reset) begin
      ph = PH_IDLE; step = 0; ticks = 0; m_shift = 0; m_sidx = 0;
      m_lastw = '0; m_loaded = 0; m_err = 0; m_pend = '0; m_coll = '0;
    end else begin
      if (m_shift) m_lastw = mem[m_sidx];
      m_shift = (ph == PH_READ);
      m_sidx  = step;
      case (ph)
        PH_IDLE:
          if (load) begin
            ph = PH_READ; step = 0; m_err = 0;
          end else if (infer) begin
            if (m_loaded) begin
              ph = PH_ASK; m_pend = '1; m_coll = '0; ticks = 0;
            end else m_err = 1;
          end
        PH_READ: begin
          step++;
          if (step == NW) begin ph = PH_TAIL; step = 0; end
        end
        PH_TAIL: begin m_loaded = 1; ph = PH_IDLE; end
        PH_ASK, PH_GATHER: begin
          if (ticks == TO - 1) begin
            m_err = 1; m_pend = '0; ph = PH_IDLE;
          end else begin
            ticks++;
            if (ph == PH_ASK) begin
              for (int i = 0; i < NI; i++) if (ack[i]) m_pend[i] = 0;
              if (m_pend == '0) ph = PH_GATHER;
            end else begin
              for (int i = 0; i < NO; i++) if (nn_req[i]) m_coll[i] = 1;
              if (m_coll == '1) ph = PH_FIN;
            end
          end
        end
        PH_FIN: ph = PH_IDLE;
        default: ph = PH_IDLE;
      endcase
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [NO-1:0] e_ack;
      e_ack = '0;
      if (ph == PH_GATHER && ticks != TO - 1) e_ack = nn_req & ~m_coll;
      chk("wmem_rd",   {31'b0, wmem_rd}, {31'b0, ph == PH_READ});
      chk("wmem_addr", {30'b0, wmem_addr}, (ph == PH_READ) ? step : 0);
      chk("shift",     {31'b0, shift}, {31'b0, m_shift});
      chk("weights",   weights, m_shift ? mem[m_sidx] : m_lastw);
      chk("req",       {30'b0, req}, {30'b0, m_pend});
      chk("nn_ack",    {30'b0, nn_ack}, {30'b0, e_ack});
      chk("busy",      {31'b0, busy}, {31'b0, ph != PH_IDLE});
      chk("loaded",    {31'b0, loaded}, {31'b0, m_loaded});
      chk("done",      {31'b0, done}, {31'b0, ph == PH_FIN});
      chk("error",     {31'b0, error}, {31'b0, m_err});
      if (shift) shifted.push_back(weights);
      if (done) done_cnt++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_shifted();
    chk("shift_count", shifted.size(), 4);
    if (shifted.size() == 4) begin
      chk("shift_w0", shifted[0], 32'hA000_000A);
      chk("shift_w1", shifted[1], 32'hB000_000B);
      chk("shift_w2", shifted[2], 32'hC000_000C);
      chk("shift_w3", shifted[3], 32'hD000_000D);
    end
  endtask

  initial begin
    mem[0] = 32'hA000_000A;
    mem[1] = 32'hB000_000B;
    mem[2] = 32'hC000_000C;
    mem[3] = 32'hD000_000D;

    // Reset
    cyc();
    chk_en = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_loaded", {31'b0, loaded}, 0);
    chk("rst_weights", weights, 0);
    chk("rst_req", {30'b0, req}, 0);

    // Inference before load
    infer = 1'b1;
    cyc();
    infer = 1'b0;
    chk("early_err", {31'b0, error}, 1);
    chk("early_busy", {31'b0, busy}, 0);

    // Simultaneous starts: load wins and clears error; infer during LOAD ignored
    shifted.delete();
    load = 1'b1; infer = 1'b1;
    cyc();
    load = 1'b0;
    chk("load_err_clr", {31'b0, error}, 0);
    chk("load_busy", {31'b0, busy}, 1);
    cyc();
    infer = 1'b0;
    cyc(3);
    chk("load_c5_loaded", {31'b0, loaded}, 0);
    cyc();
    chk("load_c6_loaded", {31'b0, loaded}, 1);
    chk("load_c6_busy", {31'b0, busy}, 0);
    check_shifted();
    cyc(2);
    chk("weights_hold", weights, 32'hD000_000D);

    // Normal inference
    infer = 1'b1;
    cyc();
    infer = 1'b0;
    chk("inf_req11", {30'b0, req}, 3);
    cyc();
    ack = 2'b01;
    cyc();
    ack = 2'b00;
    chk("inf_req10", {30'b0, req}, 2);
    cyc();
    ack = 2'b10;
    cyc();
    ack = 2'b00;
    chk("inf_req00", {30'b0, req}, 0);
    nn_req = 2'b11;
    #1;
    chk("inf_nnack", {30'b0, nn_ack}, 3);
    cyc();
    nn_req = 2'b00;
    chk("inf_done", {31'b0, done}, 1);
    cyc();
    chk("inf_idle", {31'b0, busy}, 0);
    chk("inf_done_cnt", done_cnt, 1);

    // Watchdog
    infer = 1'b1;
    cyc();
    infer = 1'b0;
    cyc(7);
    chk("wd_still_busy", {31'b0, busy}, 1);
    cyc();
    chk("wd_err", {31'b0, error}, 1);
    chk("wd_req", {30'b0, req}, 0);
    chk("wd_idle", {31'b0, busy}, 0);
    chk("wd_no_done", done_cnt, 1);

    // Reset in the middle of a load, at the second shift
    load = 1'b1;
    cyc();
    load = 1'b0;
    cyc(2);
    chk("mid_shift2", {31'b0, shift}, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid_shift", {31'b0, shift}, 0);
    chk("mid_loaded", {31'b0, loaded}, 0);
    chk("mid_busy", {31'b0, busy}, 0);
    chk("mid_weights", weights, 0);
    chk("mid_rd", {31'b0, wmem_rd}, 0);

    // Reload completes normally
    shifted.delete();
    load = 1'b1;
    cyc();
    load = 1'b0;
    cyc(5);
    chk("reload_loaded", {31'b0, loaded}, 1);
    check_shifted();
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
